// File: rtl/input_frame_conditioner.sv
// Button front end for the game: synchronizes and debounces left/right, resolves
// simultaneous presses (last pressed wins) and latches the result once per frame.
module input_frame_conditioner #(
  parameter int unsigned      DEB_W      = 16,
  parameter logic [DEB_W-1:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left,
  input  logic btn_right,
  input  logic vsync,
  output logic left,
  output logic right,
  output logic left_press,
  output logic right_press,
  output logic frame_tick
);

  localparam logic [DEB_W-1:0] CntMax = DEB_CYCLES - 1'b1;
  localparam logic [DEB_W-1:0] CntOne = DEB_W'(1);

  typedef enum logic [1:0] {StRel, StPressWait, StHeld, StRelWait} deb_state_e;
  typedef enum logic [1:0] {PrioNone, PrioLeft, PrioRight} prio_e;

  // Index 0 is the left button, index 1 the right button throughout.
  logic [1:0]       btn_raw;
  logic [1:0]       meta_q, sync_q;
  deb_state_e       state_q [2];
  deb_state_e       state_d [2];
  logic [DEB_W-1:0] cnt_q   [2];
  logic [DEB_W-1:0] cnt_d   [2];
  logic [1:0]       rise, fall;
  logic [1:0]       deb_lvl, deb_nxt;

  prio_e            prio_q, prio_d;
  logic             res_left, res_right;

  logic             vsync_last_q;
  logic             frame_tick_q, frame_tick_d;
  logic             left_q, right_q;
  logic             left_press_q, right_press_q;
  logic [1:0]       sticky_q, sticky_d;

  assign btn_raw = {btn_right, btn_left};

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StRel;
        cnt_q[i]   <= '0;
      end
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Debounce: a level change is accepted after DEB_CYCLES consecutive equal samples.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rise[i]    = 1'b0;
      fall[i]    = 1'b0;
      case (state_q[i])
        StRel: begin
          if (sync_q[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = CntOne;
          end else begin
            cnt_d[i] = '0;
          end
        end
        StPressWait: begin
          if (!sync_q[i]) begin
            state_d[i] = StRel;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
            rise[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        StHeld: begin
          if (!sync_q[i]) begin
            state_d[i] = StRelWait;
            cnt_d[i]   = CntOne;
          end
        end
        StRelWait: begin
          if (sync_q[i]) begin
            state_d[i] = StHeld;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StRel;
            cnt_d[i]   = '0;
            fall[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = StRel;
          cnt_d[i]   = '0;
        end
      endcase
      deb_lvl[i] = (state_q[i] == StHeld) || (state_q[i] == StRelWait);
      deb_nxt[i] = (state_d[i] == StHeld) || (state_d[i] == StRelWait);
    end
  end

  // A new press takes ownership; on release ownership passes to a button still held.
  always_comb begin
    prio_d = prio_q;
    if (rise[0] && rise[1]) begin
      prio_d = PrioNone;
    end else if (rise[0]) begin
      prio_d = PrioLeft;
    end else if (rise[1]) begin
      prio_d = PrioRight;
    end else if (fall[0]) begin
      prio_d = deb_nxt[1] ? PrioRight : PrioNone;
    end else if (fall[1]) begin
      prio_d = deb_nxt[0] ? PrioLeft : PrioNone;
    end
  end

  assign res_left  = deb_lvl[0] && (!deb_lvl[1] || (prio_q == PrioLeft));
  assign res_right = deb_lvl[1] && (!deb_lvl[0] || (prio_q == PrioRight));

  assign frame_tick_d = !vsync && vsync_last_q;
  // A rise coincident with the tick belongs to the next frame.
  assign sticky_d     = frame_tick_q ? rise : (sticky_q | rise);

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q        <= PrioNone;
      vsync_last_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      left_press_q  <= 1'b0;
      right_press_q <= 1'b0;
      sticky_q      <= '0;
    end else begin
      prio_q       <= prio_d;
      vsync_last_q <= vsync;
      frame_tick_q <= frame_tick_d;
      sticky_q     <= sticky_d;
      if (frame_tick_q) begin
        left_q        <= res_left;
        right_q       <= res_right;
        left_press_q  <= sticky_q[0];
        right_press_q <= sticky_q[1];
      end else begin
        left_press_q  <= 1'b0;
        right_press_q <= 1'b0;
      end
    end
  end

  assign left        = left_q;
  assign right       = right_q;
  assign left_press  = left_press_q;
  assign right_press = right_press_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_input_frame_conditioner.sv
// Scoreboard bench for input_frame_conditioner with DEB_CYCLES=4: stimulus queues the
// expected latched outputs per frame, a monitor checks them after each frame tick.
module tb_input_frame_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_left, btn_right, vsync;
  logic left, right, left_press, right_press, frame_tick;

  typedef struct packed {
    logic l;
    logic r;
    logic lp;
    logic rp;
  } exp_t;

  exp_t exp_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   n_frames = 0;
  int   ticks    = 0;
  int   stray    = 0;

  input_frame_conditioner #(
    .DEB_W      (16),
    .DEB_CYCLES (16'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .vsync       (vsync),
    .left        (left),
    .right       (right),
    .left_press  (left_press),
    .right_press (right_press),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Latch lands two edges after vsync is driven low.
  task automatic vsync_fall(input logic l, input logic r, input logic lp, input logic rp);
    exp_t e;
    e.l = l; e.r = r; e.lp = lp; e.rp = rp;
    exp_q.push_back(e);
    n_frames++;
    vsync = 1'b0;
    cyc(3);
    vsync = 1'b1;
    cyc(3);
  endtask

  task automatic frame(input logic l, input logic r, input logic lp, input logic rp);
    cyc(10);
    vsync_fall(l, r, lp, rp);
  endtask

  // Monitor: the cycle after frame_tick presents the latched frame values.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (frame_tick) begin
        ticks++;
        @(posedge clk);
        #2;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tick: got a frame tick, expected none (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_left", left, e.l);
          check("frame_right", right, e.r);
          check("frame_left_press", left_press, e.lp);
          check("frame_right_press", right_press, e.rp);
        end
      end else if (left_press || right_press) begin
        stray++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    vsync     = 1'b1;
    cyc(3);
    check("reset_left", left, 1'b0);
    check("reset_right", right, 1'b0);
    check("reset_left_press", left_press, 1'b0);
    check("reset_right_press", right_press, 1'b0);
    check("reset_frame_tick", frame_tick, 1'b0);
    reset = 1'b1;
    cyc(6);

    // Clean press, held across two frames, then released.
    btn_left = 1'b1;
    frame(1'b1, 1'b0, 1'b1, 1'b0);
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    btn_left = 1'b0;
    frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Bounce shorter than the debounce window.
    for (int i = 0; i < 2; i++) begin
      btn_left = 1'b1;
      cyc(2);
      btn_left = 1'b0;
      cyc(2);
    end
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Last pressed wins, ownership returns to left when right releases.
    btn_left = 1'b1;
    frame(1'b1, 1'b0, 1'b1, 1'b0);
    btn_right = 1'b1;
    frame(1'b0, 1'b1, 1'b0, 1'b1);
    btn_right = 1'b0;
    frame(1'b1, 1'b0, 1'b0, 1'b0);
    btn_left = 1'b0;
    frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous press resolves to neither.
    btn_left  = 1'b1;
    btn_right = 1'b1;
    frame(1'b0, 1'b0, 1'b1, 1'b1);
    frame(1'b0, 1'b0, 1'b0, 1'b0);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    cyc(10);
    btn_left = 1'b1;
    frame(1'b1, 1'b0, 1'b1, 1'b0);
    btn_left = 1'b0;
    frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Press and release within one frame: no level, one press pulse.
    btn_left = 1'b1;
    cyc(10);
    btn_left = 1'b0;
    frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Latch left high so the reset below has something to clear.
    btn_left = 1'b1;
    frame(1'b1, 1'b0, 1'b1, 1'b0);

    // Reset while right debounce is at cnt=2.
    btn_left  = 1'b0;
    btn_right = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(1);
    check("midreset_left", left, 1'b0);
    check("midreset_right", right, 1'b0);
    check("midreset_left_press", left_press, 1'b0);
    check("midreset_right_press", right_press, 1'b0);
    check("midreset_frame_tick", frame_tick, 1'b0);
    reset = 1'b1;
    // Tick coincides with the rise: level not yet seen, press deferred one frame.
    cyc(4);
    vsync_fall(1'b0, 1'b0, 1'b0, 1'b0);
    vsync_fall(1'b0, 1'b1, 1'b0, 1'b1);
    btn_right = 1'b0;
    frame(1'b0, 1'b0, 1'b0, 1'b0);

    cyc(5);
    check_n("tick_count", ticks, n_frames);
    check_n("scoreboard_left", exp_q.size(), 0);
    check_n("stray_press_pulses", stray, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
